// File: rtl/soc_ram_copy.sv
// soc_ram_copy: block-copy initiator for port B of the SoC dual-port data RAM.
// A host strobe latches source, destination and length. The block then moves
// that run of 16-bit words one at a time: a read cycle followed by a write cycle.
// The RAM has a 1-cycle registered read, so the word read in RD appears on
// ram_dout during WR and is passed straight through to ram_din.
// Optional feature macro: SOC_RAM_COPY_FILL_EN. When it is defined, cfg_fill=1
// writes cfg_pattern to every destination word instead of copying.
module soc_ram_copy #(
   parameter int ADDR_MSB = 6,
   parameter int LEN_MSB  = 7
) (
   input  logic                mclk,
   input  logic                puc_rst,
   input  logic                cfg_start,
   input  logic                cfg_abort,
   input  logic [ADDR_MSB:0]   cfg_src,
   input  logic [ADDR_MSB:0]   cfg_dst,
   input  logic [LEN_MSB:0]    cfg_len,
   input  logic                cfg_fill,
   input  logic [15:0]         cfg_pattern,
   output logic                busy,
   output logic                done,
   output logic [LEN_MSB:0]    remaining,
   output logic [ADDR_MSB:0]   ram_addr,
   output logic                ram_cen,
   output logic [1:0]          ram_wen,
   output logic [15:0]         ram_din,
   input  logic [15:0]         ram_dout
);

   localparam int AW = ADDR_MSB + 1;
   localparam int LW = LEN_MSB + 1;

   localparam logic [AW-1:0] ADDR_ONE = AW'(1'b1);
   localparam logic [LW-1:0] LEN_ONE  = LW'(1'b1);
   localparam logic [LW-1:0] LEN_ZERO = LW'(1'b0);
   localparam logic [1:0]    WEN_READ  = 2'b11;
   localparam logic [1:0]    WEN_WRITE = 2'b00;

`ifdef SOC_RAM_COPY_FILL_EN
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RD   = 3'd1,
      ST_WR   = 3'd2,
      ST_FILL = 3'd3,
      ST_DONE = 3'd4
   } state_t;
`else
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RD   = 3'd1,
      ST_WR   = 3'd2,
      ST_DONE = 3'd4
   } state_t;
`endif

   state_t           state_q, state_d;
   logic [AW-1:0]    src_q, src_d;
   logic [AW-1:0]    dst_q, dst_d;
   logic [LW-1:0]    rem_q, rem_d;

`ifdef SOC_RAM_COPY_FILL_EN
   logic [15:0]      pattern_q, pattern_d;
`else
   // Fill controls have no function in a copy-only build.
   logic             unused_cfg_s;
   assign unused_cfg_s = ^{cfg_fill, cfg_pattern};
`endif

   // Next-state logic: start latching, pointer stepping, abort and termination.
   always_comb begin
      state_d   = state_q;
      src_d     = src_q;
      dst_d     = dst_q;
      rem_d     = rem_q;
`ifdef SOC_RAM_COPY_FILL_EN
      pattern_d = pattern_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (cfg_start) begin
               src_d = cfg_src;
               dst_d = cfg_dst;
               rem_d = cfg_len;
`ifdef SOC_RAM_COPY_FILL_EN
               pattern_d = cfg_pattern;
               if (cfg_len == LEN_ZERO) begin
                  state_d = ST_DONE;
               end else if (cfg_fill) begin
                  state_d = ST_FILL;
               end else begin
                  state_d = ST_RD;
               end
`else
               if (cfg_len == LEN_ZERO) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_RD;
               end
`endif
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RD: begin
            if (cfg_abort) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_WR;
            end
         end
         ST_WR: begin
            if (cfg_abort) begin
               state_d = ST_DONE;
            end else begin
               src_d = src_q + ADDR_ONE;
               dst_d = dst_q + ADDR_ONE;
               rem_d = rem_q - LEN_ONE;
               if (rem_q == LEN_ONE) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_RD;
               end
            end
         end
`ifdef SOC_RAM_COPY_FILL_EN
         ST_FILL: begin
            if (cfg_abort) begin
               state_d = ST_DONE;
            end else begin
               dst_d = dst_q + ADDR_ONE;
               rem_d = rem_q - LEN_ONE;
               if (rem_q == LEN_ONE) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_FILL;
               end
            end
         end
`endif
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge mclk) begin
      if (puc_rst) begin
         state_q   <= ST_IDLE;
         src_q     <= '0;
         dst_q     <= '0;
         rem_q     <= '0;
`ifdef SOC_RAM_COPY_FILL_EN
         pattern_q <= 16'h0000;
`endif
      end else begin
         state_q   <= state_d;
         src_q     <= src_d;
         dst_q     <= dst_d;
         rem_q     <= rem_d;
`ifdef SOC_RAM_COPY_FILL_EN
         pattern_q <= pattern_d;
`endif
      end
   end

   // RAM port decode from registered state. An abort releases chip enable in
   // the same cycle, so the access scheduled for that cycle never reaches the RAM.
   always_comb begin
      ram_addr = '0;
      ram_cen  = 1'b1;
      ram_wen  = WEN_READ;
      ram_din  = 16'h0000;
      case (state_q)
         ST_RD: begin
            ram_addr = src_q;
            ram_cen  = cfg_abort;
            ram_wen  = WEN_READ;
         end
         ST_WR: begin
            ram_addr = dst_q;
            ram_cen  = cfg_abort;
            ram_wen  = cfg_abort ? WEN_READ : WEN_WRITE;
            ram_din  = ram_dout;
         end
`ifdef SOC_RAM_COPY_FILL_EN
         ST_FILL: begin
            ram_addr = dst_q;
            ram_cen  = cfg_abort;
            ram_wen  = cfg_abort ? WEN_READ : WEN_WRITE;
            ram_din  = pattern_q;
         end
`endif
         default: begin
            ram_addr = '0;
            ram_cen  = 1'b1;
            ram_wen  = WEN_READ;
            ram_din  = 16'h0000;
         end
      endcase
   end

   // Host status decode: busy covers every RAM-active state, done is the DONE state.
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state_q)
         ST_RD:   busy = 1'b1;
         ST_WR:   busy = 1'b1;
`ifdef SOC_RAM_COPY_FILL_EN
         ST_FILL: busy = 1'b1;
`endif
         ST_DONE: done = 1'b1;
         default: begin
            busy = 1'b0;
            done = 1'b0;
         end
      endcase
   end

   assign remaining = rem_q;

endmodule

// File: tb/tb_soc_ram_copy.sv
// Scoreboard bench for soc_ram_copy. Each test pushes its hand-computed RAM
// writes and done events. A negedge monitor pops one entry for every write or
// done pulse the DUT presents and compares it.
module tb_soc_ram_copy;

   logic        mclk = 1'b0;
   logic        puc_rst;
   logic        cfg_start, cfg_abort, cfg_fill;
   logic [6:0]  cfg_src, cfg_dst;
   logic [7:0]  cfg_len;
   logic [15:0] cfg_pattern;
   logic        busy, done;
   logic [7:0]  remaining;
   logic [6:0]  ram_addr;
   logic        ram_cen;
   logic [1:0]  ram_wen;
   logic [15:0] ram_din, ram_dout;

   // Bench-side port A, used only for preloading.
   logic        pa_we;
   logic [6:0]  pa_addr;
   logic [15:0] pa_data;
   logic [15:0] mem [0:127];

   typedef struct packed { logic [6:0] a; logic [15:0] d; } wr_t;
   typedef struct packed { logic [31:0] c; logic [7:0] r; } dn_t;
   wr_t wq[$];
   dn_t dq[$];
   wr_t mw;
   dn_t md;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   always #5 mclk = ~mclk;

   soc_ram_copy #(.ADDR_MSB(6), .LEN_MSB(7)) dut (
      .mclk(mclk), .puc_rst(puc_rst), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
      .cfg_src(cfg_src), .cfg_dst(cfg_dst), .cfg_len(cfg_len), .cfg_fill(cfg_fill),
      .cfg_pattern(cfg_pattern), .busy(busy), .done(done), .remaining(remaining),
      .ram_addr(ram_addr), .ram_cen(ram_cen), .ram_wen(ram_wen), .ram_din(ram_din),
      .ram_dout(ram_dout)
   );

   always @(posedge mclk) cyc <= cyc + 1;

   // Dual-port RAM model: registered-address read on port B, byte-masked writes.
   always @(posedge mclk) begin
      if (pa_we) mem[pa_addr] <= pa_data;
      if (!ram_cen) begin
         if (ram_wen == 2'b11) begin
            ram_dout <= mem[ram_addr];
         end else begin
            if (!ram_wen[0]) mem[ram_addr][7:0]  <= ram_din[7:0];
            if (!ram_wen[1]) mem[ram_addr][15:8] <= ram_din[15:8];
         end
      end
   end

   // Monitor: compare every observed write and done pulse against the scoreboard.
   always @(negedge mclk) begin
      if (ram_cen == 1'b0 && ram_wen == 2'b00) begin
         n_cmp++;
         if (wq.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_write actual addr=%h data=%h required none", ram_addr, ram_din);
         end else begin
            mw = wq.pop_front();
            if (ram_addr !== mw.a || ram_din !== mw.d) begin
               n_bad++;
               $display("FAIL write actual addr=%h data=%h required addr=%h data=%h",
                        ram_addr, ram_din, mw.a, mw.d);
            end
         end
      end
      if (ram_cen == 1'b0 && ram_wen != 2'b00 && ram_wen != 2'b11) begin
         n_cmp++;
         n_bad++;
         $display("FAIL partial_wen actual=%b required 00 or 11", ram_wen);
      end
      if (done === 1'b1) begin
         n_cmp++;
         if (dq.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_done actual cycle=%0d required none", cyc);
         end else begin
            md = dq.pop_front();
            if (cyc !== int'(md.c) || remaining !== md.r) begin
               n_bad++;
               $display("FAIL done actual cycle=%0d rem=%0d required cycle=%0d rem=%0d",
                        cyc, remaining, md.c, md.r);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic expw(input logic [6:0] a, input logic [15:0] d);
      wr_t e;
      e.a = a;
      e.d = d;
      wq.push_back(e);
   endtask

   task automatic preload(input logic [6:0] a, input logic [15:0] d);
      @(posedge mclk); #1;
      pa_we = 1'b1; pa_addr = a; pa_data = d;
      @(posedge mclk); #1;
      pa_we = 1'b0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_busy"}, busy, 32'd0);
      chk({tag, "_done"}, done, 32'd0);
      chk({tag, "_remaining"}, remaining, 32'd0);
      chk({tag, "_cen"}, ram_cen, 32'd1);
      chk({tag, "_wen"}, ram_wen, 32'd3);
      chk({tag, "_addr"}, ram_addr, 32'd0);
      chk({tag, "_din"}, ram_din, 32'd0);
   endtask

   // Issue one transfer and step through it. Cycle 0 is the start cycle.
   task automatic xfer(input logic [6:0] src, input logic [6:0] dst, input logic [7:0] len,
                       input logic fill, input logic [15:0] pat, input int busy_hi,
                       input int done_at, input logic [7:0] done_rem, input int abort_at,
                       input int restart_at, input int rst_at, input int ncyc);
      int t0;
      dn_t e;
      @(posedge mclk); #1;
      t0 = cyc;
      cfg_src = src; cfg_dst = dst; cfg_len = len; cfg_fill = fill; cfg_pattern = pat;
      cfg_start = 1'b1;
      if (done_at >= 0) begin
         e.c = t0 + done_at;
         e.r = done_rem;
         dq.push_back(e);
      end
      for (int r = 0; r <= ncyc; r++) begin
         if (r > 0) begin
            @(posedge mclk); #1;
            cfg_start = 1'b0; cfg_abort = 1'b0; puc_rst = 1'b0;
            if (r == abort_at) cfg_abort = 1'b1;
            if (r == restart_at) begin
               cfg_start = 1'b1; cfg_src = 7'h00; cfg_dst = 7'h70; cfg_len = 8'd1;
            end
            if (r == rst_at) puc_rst = 1'b1;
         end
         @(negedge mclk);
         chk("busy", busy, {31'd0, (r >= 1 && r <= busy_hi)});
         if (r == abort_at) chk("abort_cen", ram_cen, 32'd1);
         if (len == 8'd0) chk("len0_cen", ram_cen, 32'd1);
         if (rst_at >= 0 && r == rst_at + 1) chk_reset_outputs("midrst");
      end
      chk("wq_drained", wq.size(), 32'd0);
      chk("dq_drained", dq.size(), 32'd0);
   endtask

   initial begin
      puc_rst = 1'b1; cfg_start = 1'b0; cfg_abort = 1'b0; cfg_fill = 1'b0;
      cfg_src = 7'h00; cfg_dst = 7'h00; cfg_len = 8'd0; cfg_pattern = 16'h0000;
      pa_we = 1'b0; pa_addr = 7'h00; pa_data = 16'h0000;
      preload(7'h10, 16'hA001);
      preload(7'h11, 16'hA002);
      preload(7'h12, 16'hA003);
      preload(7'h13, 16'hA004);
      preload(7'h20, 16'h1111);
      preload(7'h21, 16'h2222);
      preload(7'h22, 16'h3333);
      @(negedge mclk);
      chk_reset_outputs("reset");
      @(posedge mclk); #1;
      puc_rst = 1'b0;

      // Basic copy of 4 words.
      expw(7'h40, 16'hA001); expw(7'h41, 16'hA002); expw(7'h42, 16'hA003); expw(7'h43, 16'hA004);
      xfer(7'h10, 7'h40, 8'd4, 1'b0, 16'h0000, 8, 9, 8'd0, -1, -1, -1, 11);
      chk("copy_remaining", remaining, 32'd0);
      chk("copy_mem43", mem[7'h43], 32'h0000A004);

      // Zero-length transfer.
      xfer(7'h10, 7'h44, 8'd0, 1'b0, 16'h0000, 0, 1, 8'd0, -1, -1, -1, 3);
      chk("len0_remaining", remaining, 32'd0);

`ifdef SOC_RAM_COPY_FILL_EN
      // Fill with destination wrap.
      expw(7'h7E, 16'h5A5A); expw(7'h7F, 16'h5A5A); expw(7'h00, 16'h5A5A);
      xfer(7'h10, 7'h7E, 8'd3, 1'b1, 16'h5A5A, 3, 4, 8'd0, -1, -1, -1, 6);
`else
      // Fill request in a copy-only build: copies with destination wrap.
      expw(7'h7E, 16'hA001); expw(7'h7F, 16'hA002); expw(7'h00, 16'hA003);
      xfer(7'h10, 7'h7E, 8'd3, 1'b1, 16'h5A5A, 6, 7, 8'd0, -1, -1, -1, 9);
`endif
      chk("wrap_mem00", mem[7'h00][15:8] == 8'h5A || mem[7'h00][15:8] == 8'hA0, 32'd1);

      // Abort in cycle 5 of an 8-word copy.
      expw(7'h50, 16'hA001); expw(7'h51, 16'hA002);
      xfer(7'h10, 7'h50, 8'd8, 1'b0, 16'h0000, 5, 6, 8'd6, 5, -1, -1, 9);
      chk("abort_remaining", remaining, 32'd6);
      chk("abort_mem52", mem[7'h52], 32'h00000000);

      // Overlapping forward copy re-reads written words.
      expw(7'h21, 16'h1111); expw(7'h22, 16'h1111); expw(7'h23, 16'h1111);
      xfer(7'h20, 7'h21, 8'd3, 1'b0, 16'h0000, 6, 7, 8'd0, -1, -1, -1, 9);
      chk("overlap_mem23", mem[7'h23], 32'h00001111);

      // Start pulsed while busy is ignored.
      expw(7'h60, 16'hA001); expw(7'h61, 16'hA002); expw(7'h62, 16'hA003); expw(7'h63, 16'hA004);
      xfer(7'h10, 7'h60, 8'd4, 1'b0, 16'h0000, 8, 9, 8'd0, -1, 3, -1, 12);
      chk("restart_mem70", mem[7'h70], 32'h00000000);

      // Reset during the first write cycle: that write lands, no done pulse.
      expw(7'h68, 16'hA001);
      xfer(7'h10, 7'h68, 8'd4, 1'b0, 16'h0000, 2, -1, 8'd0, -1, -1, 2, 8);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
